// File: rtl/eth_tx_frame_arbiter_if.sv
// Avalon-ST link used on both sides of the TX frame arbiter.
//   valid   : beat valid (source -> sink)
//   data    : beat payload, DATA_W bits
//   sop/eop : start / end of packet markers
//   error   : beat error flag
//   channel : source index (driven on the arbiter output link only)
//   ready   : sink can accept a beat this cycle (sink -> source)
// master modport : the side that sources beats.
// slave modport  : the side that sinks beats.
interface eth_tx_frame_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              sop;
  logic              eop;
  logic              error;
  logic              channel;
  logic              ready;

  modport master (
    output valid, data, sop, eop, error, channel,
    input  ready
  );

  modport slave (
    input  valid, data, sop, eop, error,
    output ready
  );
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one Ethernet MAC TX Avalon-ST
// input from two sources (0: firewall forward path, 1: local/control path).
// A grant is taken on an SOP beat and held until that frame's EOP handshake.
// If the granted source stalls mid-frame for TIMEOUT cycles the frame is
// closed on the output with an error/EOP beat and the rest of the stalled
// frame is discarded.
//
// Ports:
//   Clk          : MAC clock
//   Rst_n        : asynchronous active-low reset
//   S0_avalonST  : source 0 input link (slave)
//   S1_avalonST  : source 1 input link (slave)
//   M_avalonST   : output link to MAC TX (master); channel = granted source
//   abort_pulse  : one-cycle pulse when the abort beat is accepted
//   abort_count  : saturating number of aborted frames
module eth_tx_frame_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  eth_tx_frame_arbiter_if.slave  S0_avalonST,
  eth_tx_frame_arbiter_if.slave  S1_avalonST,
  eth_tx_frame_arbiter_if.master M_avalonST,
  output logic                   abort_pulse,
  output logic [CNT_W-1:0]       abort_count
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ABORT,
    DROP
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              grant, grant_nxt;
  logic              last_grant, last_grant_nxt;
  logic [CNT_W-1:0]  idle_cnt, idle_cnt_nxt;

  // Granted-source view (zero-latency mux)
  logic              g_valid;
  logic [DATA_W-1:0] g_data;
  logic              g_sop;
  logic              g_eop;
  logic              g_error;
  logic              g_ready;

  logic              req0, req1;
  logic              orphan_rdy0, orphan_rdy1;

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_sop;
  logic              m_eop;
  logic              m_error;
  logic              m_channel;

  always_comb begin
    if (grant) begin
      g_valid = S1_avalonST.valid;
      g_data  = S1_avalonST.data;
      g_sop   = S1_avalonST.sop;
      g_eop   = S1_avalonST.eop;
      g_error = S1_avalonST.error;
    end else begin
      g_valid = S0_avalonST.valid;
      g_data  = S0_avalonST.data;
      g_sop   = S0_avalonST.sop;
      g_eop   = S0_avalonST.eop;
      g_error = S0_avalonST.error;
    end
  end

  assign req0 = S0_avalonST.valid & S0_avalonST.sop;
  assign req1 = S1_avalonST.valid & S1_avalonST.sop;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      idle_cnt    <= '0;
      abort_count <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      idle_cnt   <= idle_cnt_nxt;
      if (abort_pulse && (abort_count != '1)) begin
        abort_count <= abort_count + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    idle_cnt_nxt   = idle_cnt;
    m_valid        = 1'b0;
    m_data         = '0;
    m_sop          = 1'b0;
    m_eop          = 1'b0;
    m_error        = 1'b0;
    m_channel      = 1'b0;
    g_ready        = 1'b0;
    orphan_rdy0    = 1'b0;
    orphan_rdy1    = 1'b0;
    abort_pulse    = 1'b0;

    unique case (state)
      IDLE: begin
        idle_cnt_nxt = '0;
        // Beats without SOP outside a frame are swallowed so a source that
        // lost sync cannot block the link.
        orphan_rdy0  = S0_avalonST.valid & ~S0_avalonST.sop;
        orphan_rdy1  = S1_avalonST.valid & ~S1_avalonST.sop;
        if (req0 || req1) begin
          grant_nxt = (req0 && req1) ? ~last_grant : req1;
          state_nxt = SEND;
        end
      end

      SEND: begin
        m_valid   = g_valid;
        m_data    = g_data;
        m_sop     = g_sop;
        m_eop     = g_eop;
        m_error   = g_error;
        m_channel = grant;
        g_ready   = M_avalonST.ready;
        if (g_valid) begin
          // Sink backpressure is not a source stall: the counter only runs
          // while the granted source itself has nothing to offer.
          idle_cnt_nxt = '0;
          if (M_avalonST.ready && g_eop) begin
            last_grant_nxt = grant;
            state_nxt      = IDLE;
          end
        end else if (idle_cnt == IDLE_LIMIT) begin
          state_nxt = ABORT;
        end else begin
          idle_cnt_nxt = idle_cnt + CNT_W'(1);
        end
      end

      ABORT: begin
        m_valid   = 1'b1;
        m_eop     = 1'b1;
        m_error   = 1'b1;
        m_channel = grant;
        if (M_avalonST.ready) begin
          abort_pulse    = 1'b1;
          last_grant_nxt = grant;
          state_nxt      = DROP;
        end
      end

      DROP: begin
        idle_cnt_nxt = '0;
        // A fresh SOP means the stalled frame will never finish; leave it
        // unconsumed so it is arbitrated as a normal new frame.
        g_ready = ~(g_valid & g_sop);
        if (g_valid) begin
          if (g_sop || g_eop) begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign M_avalonST.valid   = m_valid;
  assign M_avalonST.data    = m_data;
  assign M_avalonST.sop     = m_sop;
  assign M_avalonST.eop     = m_eop;
  assign M_avalonST.error   = m_error;
  assign M_avalonST.channel = m_channel;

  // Readies are gated by reset so an orphan beat is not consumed while the
  // block is held in reset.
  assign S0_avalonST.ready = Rst_n & (orphan_rdy0 | (g_ready & ~grant));
  assign S1_avalonST.ready = Rst_n & (orphan_rdy1 | (g_ready &  grant));

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
module tb_eth_tx_frame_arbiter;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  logic             Clk;
  logic             Rst_n;
  logic             abort_pulse;
  logic [CNT_W-1:0] abort_count;

  eth_tx_frame_arbiter_if #(.DATA_W(DATA_W)) s0_if ();
  eth_tx_frame_arbiter_if #(.DATA_W(DATA_W)) s1_if ();
  eth_tx_frame_arbiter_if #(.DATA_W(DATA_W)) m_if ();

  eth_tx_frame_arbiter #(
    .DATA_W (DATA_W),
    .TIMEOUT(8),
    .CNT_W  (CNT_W)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .S0_avalonST(s0_if),
    .S1_avalonST(s1_if),
    .M_avalonST (m_if),
    .abort_pulse(abort_pulse),
    .abort_count(abort_count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  beat_t       s0_q[$];
  beat_t       s1_q[$];
  logic [12:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] m_pack();
    return {m_if.valid, m_if.data, m_if.sop, m_if.eop, m_if.error, m_if.channel};
  endfunction

  function automatic logic [12:0] bt(input logic [7:0] d, input logic sop,
                                     input logic eop, input logic err, input logic ch);
    return {1'b1, d, sop, eop, err, ch};
  endfunction

  function automatic beat_t mk(input logic [7:0] d, input logic sop, input logic eop);
    beat_t b;
    b.d   = d;
    b.sop = sop;
    b.eop = eop;
    return b;
  endfunction

  task automatic drv0(input logic v, input logic [7:0] d, input logic sop,
                      input logic eop, input logic err);
    s0_if.valid = v; s0_if.data = d; s0_if.sop = sop; s0_if.eop = eop; s0_if.error = err;
  endtask

  task automatic drv1(input logic v, input logic [7:0] d, input logic sop,
                      input logic eop, input logic err);
    s1_if.valid = v; s1_if.data = d; s1_if.sop = sop; s1_if.eop = eop; s1_if.error = err;
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Feeds the source queues, checks every accepted output beat against exp_q.
  task automatic run_frames(input string tag, input int budget, input bit bp);
    int   n;
    logic r0, r1;
    n = 0;
    while ((exp_q.size() > 0 || s0_q.size() > 0 || s1_q.size() > 0) && n < budget) begin
      if (s0_q.size() > 0) drv0(1'b1, s0_q[0].d, s0_q[0].sop, s0_q[0].eop, 1'b0);
      else                 drv0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (s1_q.size() > 0) drv1(1'b1, s1_q[0].d, s1_q[0].sop, s1_q[0].eop, 1'b0);
      else                 drv1(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      m_if.ready = bp ? ~n[0] : 1'b1;
      settle();
      if (m_if.valid && m_if.ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL %s_extra: observed %0h expected no beat", tag, m_pack());
        end else begin
          chk({tag, "_beat"}, m_pack(), exp_q.pop_front());
        end
      end
      if (bp && m_if.valid && m_if.channel) chk({tag, "_s1_ready"}, s1_if.ready, m_if.ready);
      r0 = s0_if.ready;
      r1 = s1_if.ready;
      cyc();
      if (r0 && s0_q.size() > 0) void'(s0_q.pop_front());
      if (r1 && s1_q.size() > 0) void'(s1_q.pop_front());
      n++;
    end
    if (n >= budget) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_timeout: observed %0d beats left expected 0", tag, exp_q.size());
      exp_q.delete(); s0_q.delete(); s1_q.delete();
    end
    drv0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drv1(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    m_if.ready = 1'b1;
  endtask

  initial begin
    s0_if.channel = 1'b0;
    s1_if.channel = 1'b0;
    m_if.ready    = 1'b1;
    drv0(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    drv1(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    Rst_n = 1'b0;
    #2;
    // Reset state
    chk("rst_m", m_pack(), 13'h0);
    chk("rst_s0_ready", s0_if.ready, 1'b0);
    chk("rst_s1_ready", s1_if.ready, 1'b0);
    chk("rst_abort_count", abort_count, 16'h0);
    chk("rst_abort_pulse", abort_pulse, 1'b0);
    drv0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc();
    Rst_n = 1'b1;
    cyc();

    // Both sources tie each round: grants alternate 0,1,0,1,0,1
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        s0_q.push_back(mk(8'(8'h40 + 16 * k + i), i == 0, i == 2));
        s1_q.push_back(mk(8'(8'h80 + 16 * k + i), i == 0, i == 2));
      end
    end
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(bt(8'(((f % 2) != 0 ? 8'h80 : 8'h40) + 16 * (f / 2) + i),
                           i == 0, i == 2, 1'b0, (f % 2) != 0));
      end
    end
    run_frames("fair", 60, 1'b0);

    // S0-only 4-byte frame; byte 0x13 carries an error flag
    drv0(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t1_idle_m", m_pack(), 13'h0);
    chk("t1_idle_s0_ready", s0_if.ready, 1'b0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      drv0(1'b1, 8'(8'h11 + i), i == 0, i == 3, i == 2);
      settle();
      chk("t1_beat", m_pack(), bt(8'(8'h11 + i), i == 0, i == 3, i == 2, 1'b0));
      chk("t1_s0_ready", s0_if.ready, 1'b1);
      cyc();
    end
    drv0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t1_after_m", m_pack(), 13'h0);
    cyc();

    // Backpressure on an S1 frame
    for (int i = 0; i < 4; i++) begin
      s1_q.push_back(mk(8'(8'hC0 + i), i == 0, i == 3));
      exp_q.push_back(bt(8'(8'hC0 + i), i == 0, i == 3, 1'b0, 1'b1));
    end
    run_frames("bp", 30, 1'b1);
    chk("bp_abort_count", abort_count, 16'h0);

    // Watchdog abort on S0 while S1 waits with a pending frame
    drv0(1'b1, 8'h31, 1'b1, 1'b0, 1'b0);
    drv1(1'b1, 8'hD0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t4_idle_m", m_pack(), 13'h0);
    cyc();
    settle();
    chk("t4_b0", m_pack(), bt(8'h31, 1'b1, 1'b0, 1'b0, 1'b0));
    chk("t4_s1_wait", s1_if.ready, 1'b0);
    cyc();
    drv0(1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t4_b1", m_pack(), bt(8'h32, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc();
    drv0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("t4_stall_m", m_pack(), 13'h0);
      chk("t4_stall_pulse", abort_pulse, 1'b0);
      cyc();
    end
    drv0(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t4_abort_beat", m_pack(), bt(8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    chk("t4_abort_pulse", abort_pulse, 1'b1);
    chk("t4_abort_s0_ready", s0_if.ready, 1'b0);
    chk("t4_abort_s1_ready", s1_if.ready, 1'b0);
    cyc();
    settle();
    chk("t4_drop_m", m_pack(), 13'h0);
    chk("t4_drop_pulse", abort_pulse, 1'b0);
    chk("t4_abort_count", abort_count, 16'h1);
    chk("t4_drop_s0_ready", s0_if.ready, 1'b1);
    chk("t4_drop_s1_ready", s1_if.ready, 1'b0);
    cyc();
    drv0(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t4_drop_m2", m_pack(), 13'h0);
    cyc();
    drv0(1'b1, 8'h35, 1'b0, 1'b1, 1'b0);
    settle();
    chk("t4_drop_eop_ready", s0_if.ready, 1'b1);
    chk("t4_drop_m3", m_pack(), 13'h0);
    cyc();
    drv0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t4_idle2_m", m_pack(), 13'h0);
    chk("t4_idle2_s1_ready", s1_if.ready, 1'b0);
    cyc();
    settle();
    chk("t4_s1_b0", m_pack(), bt(8'hD0, 1'b1, 1'b0, 1'b0, 1'b1));
    cyc();
    drv1(1'b1, 8'hD1, 1'b0, 1'b1, 1'b0);
    settle();
    chk("t4_s1_b1", m_pack(), bt(8'hD1, 1'b0, 1'b1, 1'b0, 1'b1));
    cyc();
    drv1(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t4_end_m", m_pack(), 13'h0);
    cyc();

    // Abort, then a new SOP arrives during DROP
    drv0(1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t5_idle_m", m_pack(), 13'h0);
    cyc();
    settle();
    chk("t5_b0", m_pack(), bt(8'h41, 1'b1, 1'b0, 1'b0, 1'b0));
    cyc();
    drv0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc();
    settle();
    chk("t5_abort_beat", m_pack(), bt(8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    chk("t5_abort_pulse", abort_pulse, 1'b1);
    cyc();
    drv0(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t5_drop_ready", s0_if.ready, 1'b1);
    chk("t5_drop_m", m_pack(), 13'h0);
    cyc();
    drv0(1'b1, 8'h50, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t5_drop_sop_ready", s0_if.ready, 1'b0);
    chk("t5_drop_sop_m", m_pack(), 13'h0);
    cyc();
    settle();
    chk("t5_rearb_ready", s0_if.ready, 1'b0);
    chk("t5_rearb_m", m_pack(), 13'h0);
    cyc();
    settle();
    chk("t5_new_b0", m_pack(), bt(8'h50, 1'b1, 1'b0, 1'b0, 1'b0));
    chk("t5_new_ready", s0_if.ready, 1'b1);
    cyc();
    drv0(1'b1, 8'h51, 1'b0, 1'b1, 1'b0);
    settle();
    chk("t5_new_b1", m_pack(), bt(8'h51, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc();
    drv0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t5_abort_count", abort_count, 16'h2);
    chk("t5_end_m", m_pack(), 13'h0);
    cyc();

    // Reset in the middle of a frame
    drv0(1'b1, 8'h61, 1'b1, 1'b0, 1'b0);
    cyc();
    settle();
    chk("t6_b0", m_pack(), bt(8'h61, 1'b1, 1'b0, 1'b0, 1'b0));
    cyc();
    drv0(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
    cyc();
    drv0(1'b1, 8'h63, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t6_b2", m_pack(), bt(8'h63, 1'b0, 1'b0, 1'b0, 1'b0));
    Rst_n = 1'b0;
    #1;
    chk("t6_rst_m", m_pack(), 13'h0);
    chk("t6_rst_s0_ready", s0_if.ready, 1'b0);
    chk("t6_rst_abort_count", abort_count, 16'h0);
    drv0(1'b1, 8'h71, 1'b1, 1'b1, 1'b0);
    drv1(1'b1, 8'h81, 1'b1, 1'b1, 1'b0);
    cyc();
    cyc();
    chk("t6_rst_hold_m", m_pack(), 13'h0);
    Rst_n = 1'b1;
    settle();
    chk("t6_rel_m", m_pack(), 13'h0);
    cyc();
    settle();
    chk("t6_tie_s0", m_pack(), bt(8'h71, 1'b1, 1'b1, 1'b0, 1'b0));
    chk("t6_tie_s1_ready", s1_if.ready, 1'b0);
    cyc();
    drv0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t6_idle_m", m_pack(), 13'h0);
    cyc();
    settle();
    chk("t6_s1", m_pack(), bt(8'h81, 1'b1, 1'b1, 1'b0, 1'b1));
    cyc();
    drv1(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t6_end_m", m_pack(), 13'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
